mux_a_reg: RTL and testbench
============================

Name: mux_a_reg

Overview:
- Registered, parametrised successor to the accumulator-source mux for the next processor generation.
- Selects one of N_CH data sources by a binary select, captures it through a one-entry valid/ready output register, and holds the last good value on an illegal select. It never infers a latch.
- Sits between the datapath sources (ULA, data memory, extender, future channels) and the accumulator load port.

Parameters:
- DATA_WIDTH, 11, width of each data channel and of the output.
- N_CH, 3, number of source channels; legal range 2..16.
- SEL_W, $clog2(N_CH), select width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_in  in  N_CH*DATA_WIDTH  packed sources; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- sel  in  SEL_W  channel select; code k selects channel k.
- in_valid  in  1  sel and src_in are valid this cycle.
- in_ready  out  1  block can accept this cycle.
- out_data  out  DATA_WIDTH  registered selected value.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer (accumulator) takes out_data this cycle.
- sel_err  out  1  sticky: an illegal select (sel >= N_CH) was accepted.
- last_sel  out  SEL_W  select code of the last legal capture.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, sel_err=0, last_sel=0, state=EMPTY.
- Two-state FSM:
  - EMPTY: in_ready=1. On in_valid with a legal sel, capture the selected channel into out_data, set last_sel=sel, go to FULL.
  - FULL: out_valid=1, in_ready=out_ready (pass-through ready, no skid buffer).
    - out_ready && in_valid && legal sel: recapture in the same cycle; stay FULL.
    - out_ready && !in_valid: go to EMPTY.
    - !out_ready: hold out_data stable; stay FULL.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1 transfer/cycle while out_ready=1.
- Illegal sel (>= N_CH, possible only when N_CH is not a power of 2) with an accepted input (in_valid && in_ready):
  - sets sel_err;
  - leaves out_data and last_sel unchanged;
  - is treated as a consumed bubble: from FULL with out_ready=1, go to EMPTY; from EMPTY, stay EMPTY.
- sel_err clears only on reset.
- No arithmetic; data is passed through unchanged at full DATA_WIDTH.
- Ready/valid protocol:
  - out_data must not change while out_valid && !out_ready.
  - in_ready depends on out_ready combinationally; no other combinational in-to-out path exists.
- Reset asserted mid-transfer: output is dropped immediately; out_valid=0 within the reset assertion, independent of the clock.
- A select or data change while the block is not accepting (in_valid=0 or in_ready=0) has no effect.

Optional Feature:
- Macro MUX_A_REG_ERRCNT_EN.
- Defined: adds output err_cnt, 8 bits, reset 0. It increments on every accepted illegal select and saturates at 255.
- Not defined: the port is absent and no counter logic is generated.
- sel_err behaviour is identical in both builds.

Decomposition:
- Shared package mux_a_pkg:
  - state enum mux_state_t {EMPTY, FULL};
  - legacy select constants SEL_DATA_MEMORY=0, SEL_EXT=1, SEL_ULA=2;
  - ERRCNT_W=8.
- No sub-module; channel selection is an indexed part-select inside one always_comb block.

Test Plan:
- Reset, then in_valid=1, sel=2, ch2=0x3A5, out_ready=1 -> out_valid=1 and out_data=0x3A5 the next cycle; last_sel=2.
- Back-to-back streaming sel=0,1,2 with ch0=0x001, ch1=0x002, ch2=0x004, out_ready=1 -> out_data 0x001, 0x002, 0x004 on 3 consecutive cycles, no bubbles.
- FULL holding 0x155, out_ready=0 for 4 cycles while ch sources toggle -> in_ready=0, out_data stays 0x155; on out_ready=1 the pending input is captured.
- N_CH=3, accepted sel=3 while FULL with 0x0F0 and out_ready=1 -> sel_err=1, out_data=0x0F0 held, out_valid=0 next cycle; with MUX_A_REG_ERRCNT_EN, err_cnt=1. 300 illegal accepts -> err_cnt=255.
- rst_n pulsed low mid-stream while FULL -> out_valid and sel_err drop asynchronously; after release, in_ready=1 and out_data=0.
- N_CH=5, DATA_WIDTH=16: sel=4, ch4=0xBEEF -> out_data=0xBEEF; sel=5..7 -> sel_err=1.

Source files
------------

// File: rtl/mux_a_pkg.sv
// Shared types and constants for the registered accumulator-source mux.
// Legacy select codes keep the old three-source mapping for existing callers.
package mux_a_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } mux_state_t;

  localparam int SEL_DATA_MEMORY = 0;
  localparam int SEL_EXT         = 1;
  localparam int SEL_ULA         = 2;

  localparam int ERRCNT_W = 8;

endpackage

// File: rtl/mux_a_reg.sv
// Registered N_CH-way source mux with a one-entry valid/ready output stage.
// Optional macro MUX_A_REG_ERRCNT_EN adds a saturating illegal-select counter (err_cnt).
//
// state | meaning
// EMPTY | output register holds no pending value; always ready
// FULL  | out_data valid; ready follows out_ready (no skid buffer)
module mux_a_reg
  import mux_a_pkg::*;
#(
  parameter int  DATA_WIDTH = 11,
  parameter int  N_CH       = 3,
  localparam int SEL_W      = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH*DATA_WIDTH-1:0] src_in,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sel_err,
  output logic [SEL_W-1:0]           last_sel
`ifdef MUX_A_REG_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]        err_cnt
`endif
);

  mux_state_t            state;
  mux_state_t            state_nxt;
  logic                  sel_legal;
  logic                  accept;
  logic                  load;
  logic [DATA_WIDTH-1:0] sel_data;

  // Out-of-range codes never index src_in; they read as zero and are never loaded.
  always_comb begin
    sel_legal = (32'(sel) < N_CH);
    sel_data  = '0;
    if (sel_legal) sel_data = src_in[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign accept = in_valid && in_ready;
  assign load   = accept && sel_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // An accepted illegal select from FULL drains the register like a bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (out_ready) state_nxt = load ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state == EMPTY) || out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      last_sel <= '0;
    end else if (load) begin
      out_data <= sel_data;
      last_sel <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     sel_err <= 1'b0;
    else if (accept && !sel_legal)  sel_err <= 1'b1;
  end

`ifdef MUX_A_REG_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (accept && !sel_legal && (err_cnt != {ERRCNT_W{1'b1}}))
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux_a_reg.sv
// Scoreboard bench for mux_a_reg: a one-entry buffer model feeds expected items
// to a queue that an independent monitor drains on output handshakes.
module tb_mux_a_reg;
  import mux_a_pkg::*;

  localparam int DW = 11;
  localparam int NC = 3;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic [NC*DW-1:0] src_in;
  logic [SW-1:0]   sel;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            sel_err;
  logic [SW-1:0]   last_sel;

  logic [5*16-1:0] src5;
  logic [2:0]      sel5;
  logic            in_valid5, in_ready5, out_valid5, out_ready5, sel_err5;
  logic [15:0]     out_data5;
  logic [2:0]      last_sel5;

`ifdef MUX_A_REG_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt;
  logic [ERRCNT_W-1:0] err_cnt5;
`endif

  mux_a_reg #(.DATA_WIDTH(DW), .N_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .src_in(src_in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .last_sel(last_sel)
`ifdef MUX_A_REG_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  mux_a_reg #(.DATA_WIDTH(16), .N_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .src_in(src5), .sel(sel5), .in_valid(in_valid5),
    .in_ready(in_ready5), .out_data(out_data5), .out_valid(out_valid5),
    .out_ready(out_ready5), .sel_err(sel_err5), .last_sel(last_sel5)
`ifdef MUX_A_REG_ERRCNT_EN
    , .err_cnt(err_cnt5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } item_t;

  item_t   sb_q[$];
  int      checks = 0;
  int      errors = 0;

  // Model state, updated one negedge after the capturing posedge.
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_last_sel;
  logic          m_err;
  int            m_cnt;
  logic          pend_push, pend_err;
  item_t         pend_item;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_data = '0; m_last_sel = '0; m_err = 1'b0; m_cnt = 0;
    pend_push = 1'b0; pend_err = 1'b0;
  endtask

  task automatic apply_pending();
    if (pend_push) begin
      sb_q.push_back(pend_item);
      m_data     = pend_item.d;
      m_last_sel = pend_item.s;
    end
    if (pend_err) begin
      m_err = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    pend_push = 1'b0;
    pend_err  = 1'b0;
  endtask

  // One bus cycle: drive on negedge, check ready combinationally, record acceptance.
  task automatic cycle(input logic iv, input logic [SW-1:0] s,
                       input logic [NC*DW-1:0] src, input logic ordy);
    logic exp_rdy;
    @(negedge clk);
    apply_pending();
    in_valid = iv; sel = s; src_in = src; out_ready = ordy;
    #1;
    exp_rdy = (sb_q.size() == 0) || ordy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (iv && exp_rdy) begin
      if (int'(s) < NC) begin
        pend_push   = 1'b1;
        pend_item.s = s;
        pend_item.d = src[int'(s)*DW +: DW];
      end else begin
        pend_err = 1'b1;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    apply_pending();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_sel_err", 32'(sel_err), 32'd0);
    model_clear();
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_data", 32'(out_data), 32'd0);
  endtask

  function automatic logic [NC*DW-1:0] rsrc();
    return {$urandom, $urandom} & {(NC*DW){1'b1}};
  endfunction

  function automatic logic [NC*DW-1:0] pack3(input logic [DW-1:0] c0, c1, c2);
    return {c2, c1, c0};
  endfunction

  // Monitor: compares presented output against the scoreboard each cycle.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      chk("out_data_held", 32'(out_data), 32'(m_data));
      chk("last_sel", 32'(last_sel), 32'(m_last_sel));
      chk("sel_err", 32'(sel_err), 32'(m_err));
`ifdef MUX_A_REG_ERRCNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
      if (out_valid && sb_q.size() != 0) begin
        it = sb_q[0];
        chk("sb_data", 32'(out_data), 32'(it.d));
        chk("sb_sel", 32'(last_sel), 32'(it.s));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; sel = '0; src_in = '0; out_ready = 1'b0;
    in_valid5 = 1'b0; sel5 = '0; src5 = '0; out_ready5 = 1'b0;
    model_clear();
    #23 rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Single capture from the ULA channel.
    cycle(1'b1, 2'(SEL_ULA), pack3(11'h000, 11'h000, 11'h3A5), 1'b1);
    cycle(1'b0, 2'd0, '0, 1'b1);

    // Back-to-back streaming, no bubbles.
    cycle(1'b1, 2'(SEL_DATA_MEMORY), pack3(11'h001, 11'h002, 11'h004), 1'b1);
    cycle(1'b1, 2'(SEL_EXT),         pack3(11'h001, 11'h002, 11'h004), 1'b1);
    cycle(1'b1, 2'(SEL_ULA),         pack3(11'h001, 11'h002, 11'h004), 1'b1);
    cycle(1'b0, 2'd0, '0, 1'b1);

    // Backpressure: hold 0x155 while sources toggle, then release.
    cycle(1'b1, 2'd1, pack3(11'h000, 11'h155, 11'h000), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'($urandom_range(0, 2)), rsrc(), 1'b0);
    cycle(1'b1, 2'd2, pack3(11'h000, 11'h000, 11'h2AA), 1'b1);
    cycle(1'b0, 2'd0, '0, 1'b1);

    // Illegal select while FULL drains as a bubble and keeps data.
    cycle(1'b1, 2'd0, pack3(11'h0F0, 11'h000, 11'h000), 1'b1);
    cycle(1'b1, 2'd3, rsrc(), 1'b1);
    cycle(1'b0, 2'd0, rsrc(), 1'b1);
    cycle(1'b0, 2'd0, rsrc(), 1'b0);

    // Enough illegal accepts to saturate the optional counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd3, rsrc(), 1'($urandom_range(0, 1)));

    // Reset while FULL.
    cycle(1'b1, 2'd1, rsrc(), 1'b0);
    pulse_reset();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rsrc(),
            1'($urandom_range(0, 9) < 7));
    cycle(1'b0, 2'd0, '0, 1'b1);
    cycle(1'b0, 2'd0, '0, 1'b1);

    // Wider instance: five channels, 16-bit data.
    @(negedge clk);
    apply_pending();
    in_valid5 = 1'b1; sel5 = 3'd4; out_ready5 = 1'b1;
    src5 = {16'hBEEF, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    @(negedge clk);
    #1;
    chk("n5_out_valid", 32'(out_valid5), 32'd1);
    chk("n5_out_data", 32'(out_data5), 32'hBEEF);
    chk("n5_last_sel", 32'(last_sel5), 32'd4);
    chk("n5_sel_err_clean", 32'(sel_err5), 32'd0);
    sel5 = 3'd5; src5 = {5{16'h5A5A}};
    @(negedge clk);
    #1;
    chk("n5_sel_err", 32'(sel_err5), 32'd1);
    chk("n5_bubble_valid", 32'(out_valid5), 32'd0);
    chk("n5_data_hold", 32'(out_data5), 32'hBEEF);
    sel5 = 3'd6;
    @(negedge clk);
    #1;
    sel5 = 3'd7;
    @(negedge clk);
    #1;
    in_valid5 = 1'b0;
    chk("n5_sel_err_sticky", 32'(sel_err5), 32'd1);
    chk("n5_last_sel_hold", 32'(last_sel5), 32'd4);
`ifdef MUX_A_REG_ERRCNT_EN
    chk("n5_err_cnt", 32'(err_cnt5), 32'd3);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
